// File: rtl/i2c_burst_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_burst_seq_pkg                                             |
// | Description : Shared types and constants for the I2C burst sequencer.      |
// |               Holds the sequencer state encoding, the error codes reported |
// |               on err_code, and the start admission helper.                  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package i2c_burst_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_REJ  = 2'd2;

  // A burst may launch only if it moves at least one byte and the FIFO it
  // depends on can cover the whole length up front, so the sequencer never
  // stalls mid-burst on data or space.
  function automatic logic start_fits(input logic [15:0] avail, input logic [15:0] need);
    return (need != 16'd0) && (avail >= need);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_burst_seq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_burst_seq_fifo                                            |
// | Description : Single-clock FIFO with show-ahead head and occupancy count.  |
// |               Push when full is dropped unless a pop happens in the same  |
// |               cycle; pop when empty is ignored. Pointers wrap mod depth.  |
// | Ports       : clk, rst_n      clock, async active-low reset               |
// |               i_push, i_data  write strobe and data                       |
// |               i_pop           read strobe (advances head)                 |
// |               o_head          current head entry (combinational)          |
// |               o_level         occupancy, 0..2**AW                         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module i2c_burst_seq_fifo #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [AW:0]   o_level
);

  localparam int c_DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [c_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_level == (AW+1)'(c_DEPTH));
  assign w_do_pop  = i_pop & (r_level != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/i2c_burst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_burst_seq                                                 |
// | Description : Multi-byte I2C transfer sequencer between the GPMC register |
// |               map and i2c_master. Queues TX bytes, drives the master's    |
// |               enable/addr/rw/data_wr and collects read bytes, so one host |
// |               command becomes one START..STOP burst.                      |
// | Ports       : i_start/i_slave_addr/i_rw/i_len  burst launch command        |
// |               i_tx_push/i_tx_data              TX FIFO write              |
// |               i_rx_pop/o_rx_data               RX FIFO read (registered)  |
// |               o_tx_level/o_rx_level            FIFO occupancies           |
// |               o_seq_busy/o_done/o_err_code     status, i_clr_err clears   |
// |               o_m_* / i_m_*                    i2c_master handshake       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module i2c_burst_seq
  import i2c_burst_seq_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [6:0]         i_slave_addr,
  input  logic               i_rw,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_tx_push,
  input  logic [7:0]         i_tx_data,
  input  logic               i_rx_pop,
  output logic [7:0]         o_rx_data,
  output logic [FIFO_AW:0]   o_tx_level,
  output logic [FIFO_AW:0]   o_rx_level,
  output logic               o_seq_busy,
  output logic               o_done,
  output logic [1:0]         o_err_code,
  input  logic               i_clr_err,
  output logic               o_m_enable,
  output logic [6:0]         o_m_addr,
  output logic               o_m_rw,
  output logic [7:0]         o_m_data_wr,
  input  logic               i_m_busy,
  input  logic               i_m_ack_error,
  input  logic [7:0]         i_m_data_rd
);

  localparam logic [15:0] c_FIFO_DEPTH = 16'(1 << FIFO_AW);

  seq_state_t       r_state;
  logic             r_busy_q;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_discard;
  logic             r_refresh;
  logic             r_m_enable;
  logic [6:0]       r_m_addr;
  logic             r_m_rw;
  logic [7:0]       r_m_data_wr;
  logic             r_done;
  logic             r_seq_busy;
  logic [1:0]       r_err;
  logic [7:0]       r_rx_data;

  logic [7:0]       w_tx_head;
  logic [7:0]       w_rx_head;
  logic [FIFO_AW:0] w_tx_level;
  logic [FIFO_AW:0] w_rx_level;
  logic             w_busy_rise;
  logic             w_busy_fall;
  logic             w_tx_pop;
  logic             w_rx_push;
  logic             w_start_ok;

  assign w_busy_rise = i_m_busy & ~r_busy_q;
  assign w_busy_fall = ~i_m_busy & r_busy_q;

  // TX head leaves when the master accepts a write byte, or one per cycle
  // while the unsent tail of a NACKed burst is being discarded.
  assign w_tx_pop  = ((r_state == ST_XFER) && w_busy_rise && !r_m_rw && (r_remaining != '0))
                   || ((r_state == ST_DRAIN) && (r_discard != '0));
  assign w_rx_push = (r_state == ST_XFER) && w_busy_fall && r_m_rw;

  assign w_start_ok = i_rw ? start_fits(c_FIFO_DEPTH - 16'(w_rx_level), 16'(i_len))
                           : start_fits(16'(w_tx_level), 16'(i_len));

  i2c_burst_seq_fifo #(.AW(FIFO_AW), .DW(8)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_tx_push),
    .i_data  (i_tx_data),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_level (w_tx_level)
  );

  i2c_burst_seq_fifo #(.AW(FIFO_AW), .DW(8)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_data  (i_m_data_rd),
    .i_pop   (i_rx_pop),
    .o_head  (w_rx_head),
    .o_level (w_rx_level)
  );

  // Host read port: capture the byte being popped; an empty pop holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data <= 8'h00;
    end else if (i_rx_pop && (w_rx_level != '0)) begin
      r_rx_data <= w_rx_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy_q    <= 1'b0;
      r_remaining <= '0;
      r_discard   <= '0;
      r_refresh   <= 1'b0;
      r_m_enable  <= 1'b0;
      r_m_addr    <= 7'h00;
      r_m_rw      <= 1'b0;
      r_m_data_wr <= 8'h00;
      r_done      <= 1'b0;
      r_seq_busy  <= 1'b0;
      r_err       <= ERR_NONE;
    end else begin
      r_busy_q  <= i_m_busy;
      r_done    <= 1'b0;
      r_refresh <= 1'b0;
      // Any error raised further down overrides this clear.
      if (i_clr_err) r_err <= ERR_NONE;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_start_ok) begin
              r_m_addr    <= i_slave_addr;
              r_m_rw      <= i_rw;
              r_remaining <= i_len;
              r_discard   <= '0;
              r_m_data_wr <= i_rw ? 8'h00 : w_tx_head;
              r_m_enable  <= 1'b1;
              r_seq_busy  <= 1'b1;
              r_state     <= ST_ARM;
            end else begin
              r_err <= ERR_REJ;
            end
          end
        end

        // One settle cycle: the master sees enable with stable addr/rw/data
        // before any busy edge is interpreted.
        ST_ARM: begin
          r_state <= ST_XFER;
        end

        ST_XFER: begin
          if (w_busy_rise && (r_remaining != '0)) begin
            r_remaining <= r_remaining - LEN_W'(1);
            // Last byte accepted: dropping enable now makes the master STOP.
            if (r_remaining == LEN_W'(1)) r_m_enable <= 1'b0;
            if (!r_m_rw) r_refresh <= 1'b1;
          end
          // The pop lands at the accept edge; the new head is loaded one
          // cycle later, well before the master samples data_wr again.
          if (r_refresh && !r_m_rw && (r_remaining != '0)) begin
            r_m_data_wr <= w_tx_head;
          end
          if (w_busy_fall) begin
            if (i_m_ack_error) begin
              r_err      <= ERR_NACK;
              r_m_enable <= 1'b0;
              // Bytes of this burst still queued in TX are never sent.
              r_discard  <= r_m_rw ? '0 : r_remaining;
              r_state    <= ST_DRAIN;
            end else if (r_remaining == '0) begin
              r_done     <= 1'b1;
              r_seq_busy <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end

        ST_DRAIN: begin
          if (r_discard != '0) begin
            r_discard <= r_discard - LEN_W'(1);
          end else if (!i_m_busy) begin
            r_done     <= 1'b1;
            r_seq_busy <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_tx_level  = w_tx_level;
  assign o_rx_level  = w_rx_level;
  assign o_seq_busy  = r_seq_busy;
  assign o_done      = r_done;
  assign o_err_code  = r_err;
  assign o_m_enable  = r_m_enable;
  assign o_m_addr    = r_m_addr;
  assign o_m_rw      = r_m_rw;
  assign o_m_data_wr = r_m_data_wr;

endmodule
`default_nettype wire

// File: tb/tb_i2c_burst_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_burst_seq                                              |
// | Description : Directed self-checking bench for i2c_burst_seq with a        |
// |               behavioural i2c_master model on the m_* handshake.          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_i2c_burst_seq;

  localparam int BYTE_CYC = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] slave_addr = 7'h00;
  logic       rw = 1'b0;
  logic [3:0] len = 4'd0;
  logic       tx_push = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_pop = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic [3:0] tx_level;
  logic [3:0] rx_level;
  logic       seq_busy;
  logic       done;
  logic [1:0] err_code;
  logic       m_enable;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data_wr;
  logic       m_busy = 1'b0;
  logic       m_ack_error = 1'b0;
  logic [7:0] m_data_rd = 8'h00;

  always #5 clk = ~clk;

  i2c_burst_seq #(.FIFO_AW(3), .LEN_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_slave_addr (slave_addr),
    .i_rw         (rw),
    .i_len        (len),
    .i_tx_push    (tx_push),
    .i_tx_data    (tx_data),
    .i_rx_pop     (rx_pop),
    .o_rx_data    (rx_data),
    .o_tx_level   (tx_level),
    .o_rx_level   (rx_level),
    .o_seq_busy   (seq_busy),
    .o_done       (done),
    .o_err_code   (err_code),
    .i_clr_err    (clr_err),
    .o_m_enable   (m_enable),
    .o_m_addr     (m_addr),
    .o_m_rw       (m_rw),
    .o_m_data_wr  (m_data_wr),
    .i_m_busy     (m_busy),
    .i_m_ack_error(m_ack_error),
    .i_m_data_rd  (m_data_rd)
  );

  // Behavioural master: accepts a byte when enabled and idle, stays busy for
  // BYTE_CYC cycles, then returns read data / ack status as busy falls.
  int         mdl_cnt = 0;
  int         mdl_left = 0;
  int         mdl_gap = 0;
  int         nack_at = -1;
  logic [7:0] mdl_wr [64];
  logic [7:0] mdl_rd [64];
  logic [6:0] mdl_addr = 7'h00;
  logic       mdl_rw = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy      <= 1'b0;
      m_ack_error <= 1'b0;
      m_data_rd   <= 8'h00;
      mdl_gap     <= 0;
      mdl_left    <= 0;
    end else if (m_busy) begin
      if (mdl_left == 1) begin
        m_busy      <= 1'b0;
        m_ack_error <= ((mdl_cnt - 1) == nack_at);
        m_data_rd   <= mdl_rd[mdl_cnt - 1];
        mdl_gap     <= 2;
      end
      mdl_left <= mdl_left - 1;
    end else if (mdl_gap != 0) begin
      mdl_gap <= mdl_gap - 1;
    end else if (m_enable) begin
      m_busy          <= 1'b1;
      m_ack_error     <= 1'b0;
      mdl_left        <= BYTE_CYC;
      mdl_wr[mdl_cnt] <= m_data_wr;
      mdl_addr        <= m_addr;
      mdl_rw          <= m_rw;
      mdl_cnt         <= mdl_cnt + 1;
    end
  end

  int done_cnt = 0;
  int en_cnt = 0;
  always @(negedge clk) begin
    if (done)     done_cnt <= done_cnt + 1;
    if (m_enable) en_cnt   <= en_cnt + 1;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
  endtask

  task automatic go(input logic [6:0] a, input logic r, input logic [3:0] n);
    slave_addr = a;
    rw         = r;
    len        = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    check(tag, rx_data, exp);
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 500) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, (k < 500), 1);
  endtask

  task automatic wait_cnt(input string tag, input int target);
    int k = 0;
    while (mdl_cnt < target && k < 500) begin
      tick();
      k++;
    end
    check({tag, "_accept_seen"}, (k < 500), 1);
  endtask

  initial begin
    int base;
    int d0;
    int e0;
    int k;

    // ---------------- reset state
    repeat (3) tick();
    check("rst_m_enable", m_enable, 0);
    check("rst_seq_busy", seq_busy, 0);
    rst_n = 1'b1;
    tick();
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_err", err_code, 0);
    check("rst_done", done, 0);
    check("rst_rx_data", rx_data, 0);

    // ---------------- 1: two-byte write
    base = mdl_cnt;
    push(8'hA5);
    push(8'h3C);
    check("t1_tx_level_pre", tx_level, 2);
    d0 = done_cnt;
    go(7'h50, 1'b0, 4'd2);
    check("t1_enable_after_start", m_enable, 1);
    check("t1_seq_busy", seq_busy, 1);
    wait_cnt("t1", base + 2);
    tick();
    check("t1_enable_drop_2nd_rise", m_enable, 0);
    check("t1_master_still_busy", m_busy, 1);
    wait_done("t1", d0);
    tick();
    check("t1_byte0", mdl_wr[base], 8'hA5);
    check("t1_byte1", mdl_wr[base + 1], 8'h3C);
    check("t1_addr", mdl_addr, 7'h50);
    check("t1_rw", mdl_rw, 0);
    check("t1_nbytes", mdl_cnt - base, 2);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_tx_level", tx_level, 0);
    check("t1_err", err_code, 0);
    check("t1_seq_busy_end", seq_busy, 0);

    // ---------------- 2: three-byte read
    base = mdl_cnt;
    mdl_rd[base]     = 8'h11;
    mdl_rd[base + 1] = 8'h22;
    mdl_rd[base + 2] = 8'h33;
    d0 = done_cnt;
    go(7'h21, 1'b1, 4'd3);
    wait_done("t2", d0);
    tick();
    check("t2_rw", mdl_rw, 1);
    check("t2_addr", mdl_addr, 7'h21);
    check("t2_nbytes", mdl_cnt - base, 3);
    check("t2_done_pulses", done_cnt - d0, 1);
    check("t2_rx_level", rx_level, 3);
    pop_check("t2_pop1", 8'h11);
    pop_check("t2_pop2", 8'h22);
    pop_check("t2_pop3", 8'h33);
    pop_check("t2_pop_empty_holds", 8'h33);
    check("t2_rx_level_end", rx_level, 0);

    // ---------------- 3: NACK on first byte of a three-byte write
    base = mdl_cnt;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    nack_at = base;
    d0 = done_cnt;
    go(7'h50, 1'b0, 4'd3);
    k = 0;
    while (!m_ack_error && k < 500) begin
      tick();
      k++;
    end
    check("t3_nack_seen", (k < 500), 1);
    tick();
    check("t3_enable_drop_on_nack", m_enable, 0);
    wait_done("t3", d0);
    tick();
    nack_at = -1;
    check("t3_err_nack", err_code, 1);
    check("t3_tx_discarded", tx_level, 0);
    check("t3_nbytes", mdl_cnt - base, 1);
    check("t3_byte0", mdl_wr[base], 8'h01);
    check("t3_done_pulses", done_cnt - d0, 1);
    clear_err();
    check("t3_err_cleared", err_code, 0);

    // ---------------- 4: rejected starts
    push(8'hAA);
    push(8'hBB);
    d0 = done_cnt;
    e0 = en_cnt;
    go(7'h50, 1'b0, 4'd4);
    check("t4_err_rej", err_code, 2);
    check("t4_not_busy", seq_busy, 0);
    repeat (10) tick();
    check("t4_no_enable", en_cnt - e0, 0);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_tx_level_kept", tx_level, 2);
    clear_err();
    check("t4_err_cleared", err_code, 0);
    // zero length with a simultaneous clear: the new error must stick
    clr_err = 1'b1;
    go(7'h50, 1'b0, 4'd0);
    clr_err = 1'b0;
    check("t4_len0_rej_over_clr", err_code, 2);
    clear_err();
    check("t4_err_cleared2", err_code, 0);

    // ---------------- 5: async reset mid-burst, then a clean burst
    base = mdl_cnt;
    go(7'h44, 1'b0, 4'd2);
    wait_cnt("t5a", base + 1);
    tick();
    #3 rst_n = 1'b0;
    #2;
    check("t5_enable_async", m_enable, 0);
    check("t5_seq_busy", seq_busy, 0);
    check("t5_tx_level", tx_level, 0);
    check("t5_rx_level", rx_level, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    base = mdl_cnt;
    push(8'hC1);
    push(8'hC2);
    d0 = done_cnt;
    go(7'h33, 1'b0, 4'd2);
    wait_done("t5b", d0);
    tick();
    check("t5_byte0", mdl_wr[base], 8'hC1);
    check("t5_byte1", mdl_wr[base + 1], 8'hC2);
    check("t5_addr", mdl_addr, 7'h33);
    check("t5_err", err_code, 0);
    check("t5_done_pulses", done_cnt - d0, 1);

    // ---------------- 6: overfill and push+pop at full
    for (int i = 0; i < 9; i++) push(8'(i));
    check("t6_tx_full", tx_level, 8);
    base = mdl_cnt;
    d0 = done_cnt;
    go(7'h50, 1'b0, 4'd1);
    k = 0;
    while (!m_busy && k < 500) begin
      tick();
      k++;
    end
    check("t6_busy_seen", (k < 500), 1);
    // the DUT pops at the coming edge; push in that same cycle
    tx_data = 8'h5A;
    tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
    check("t6_level_push_pop_full", tx_level, 8);
    wait_done("t6", d0);
    tick();
    check("t6_byte0", mdl_wr[base], 8'h00);
    check("t6_done_pulses", done_cnt - d0, 1);
    check("t6_tx_level_end", tx_level, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
